match_gap_logger: RTL and testbench
===================================

Name: match_gap_logger

Overview:
- Downstream consumer of the 1101 Moore pattern detector's one-cycle `dout` match pulse.
- Counts matches and measures the inter-match gap in clock cycles.
- Queues gap values in a small FIFO for a valid/ready reader, e.g. a status/CPU-side stage.
- Reports a running match count and a sticky overflow flag.

Parameters:
- GAP_W, 16, width of gap measurement; saturates at 2^GAP_W-1
- CNT_W, 16, width of match counter; saturates at 2^CNT_W-1
- DEPTH, 4, FIFO entries; power of two, >=2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset; sampled on clk rising edge
- enable  in  1  1 = accept match events; 0 = ignore them and return to IDLE
- match_in  in  1  detector dout
- clear_ovf  in  1  one-cycle pulse; clears overflow
- gap_valid  out  1  FIFO non-empty
- gap_ready  in  1  reader accepts gap_data this cycle
- gap_data  out  GAP_W  head FIFO entry; cycles between consecutive match rising edges
- match_count  out  CNT_W  matches accepted since reset
- fifo_level  out  $clog2(DEPTH+1)  entries held
- overflow  out  1  sticky; a gap was dropped because the FIFO was full

Behaviour:
- Reset (reset==0 at clk edge):
  - Outputs: gap_valid=0, gap_data=0, match_count=0, fifo_level=0, overflow=0.
  - Internal: state=IDLE, timer=0, match_prev=0, FIFO pointers=0.
- Reset asserted mid-operation discards all FIFO contents and the timer on that edge.
- Event definition: `evt = enable & match_in & ~match_prev`, where match_prev is match_in registered every cycle.
  - match_in held high for N cycles yields exactly one event.
- FSM:
  - IDLE, evt: go to ARMED, timer<=1, match_count++. No FIFO push; the first match has no predecessor.
  - ARMED, evt: push timer value into FIFO, timer<=1, match_count++.
  - ARMED, no evt: timer<=timer+1, saturating at all-ones.
  - Any state, enable==0: go to IDLE. Timer is held. FIFO, match_count and overflow are retained.
- Gap arithmetic: for events at cycles t1 and t2, the pushed value is min(t2-t1, 2^GAP_W-1). The minimum legal gap from the detector is 3.
- match_count saturates at all-ones and never wraps.
- FIFO timing:
  - A push is visible on gap_valid/gap_data the cycle after the event edge (latency 1).
  - Pop occurs when gap_valid & gap_ready.
  - gap_data is stable while gap_valid=1 and gap_ready=0.
  - gap_data is 0 when empty.
- Boundary conditions:
  - Full, push, no pop: the value is dropped, overflow<=1, and the FIFO is unchanged.
  - Full, push and pop in the same cycle: both happen, level stays DEPTH, no overflow.
  - Empty, gap_ready=1: no effect.
  - Empty, push with gap_ready=1 in the same cycle: push only; pop is impossible because gap_valid=0.
  - clear_ovf and an overflow-setting event in the same cycle: set wins, overflow stays 1.
  - Pointer wrap-around at DEPTH is handled with an extra pointer MSB for the full/empty distinction.
- fifo_level updates the same cycle as the pointers: +1 push only, -1 pop only, unchanged for both or neither.

Decomposition:
- Package `match_log_pkg`:
  - state enum `mlog_state_t` {IDLE, ARMED}.
  - Default parameter constants GAP_W_DEF, CNT_W_DEF, DEPTH_DEF.
- Sub-module `sync_fifo_vr`, parameterised WIDTH/DEPTH:
  - Ports: push, push_data, pop, head_data, level, full, empty.
  - Synchronous active-low reset.
- Top-level logic: edge detect, FSM, timer, counter, overflow.

Test Plan:
1. Reset, enable=1, match_in pulses at cycles 10, 13, 20 → match_count=3; FIFO pops 3 then 7; gap_valid high from cycle 14; fifo_level peaks at 2 with gap_ready=0.
2. match_in held high cycles 5–9, then a pulse at cycle 15 → match_count=2; single FIFO entry = 10.
3. DEPTH=4, gap_ready=0, six events spaced 4 apart → fifo_level=4, overflow=1 after the 6th event; pops yield 4,4,4,4. Pulse clear_ovf → overflow=0.
4. FIFO full with gap_ready=1 in the same cycle as an event → level stays 4, overflow stays 0, the new value is at the tail.
5. GAP_W=4, events 20 cycles apart → pushed gap=15 (saturated).
6. enable dropped between two events, then re-raised → the next event returns to ARMED with no push; reset low mid-stream → all outputs 0 on the following cycle.

Source files
------------

// File: rtl/match_log_pkg.sv
// match_log_pkg: shared state encoding and default sizes for the match gap logger.
`default_nettype none

package match_log_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } mlog_state_t;

    localparam int GAP_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_vr.sv
// sync_fifo_vr: small synchronous FIFO with a valid/ready style head output.
`default_nettype none

module sync_fifo_vr #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB separates full (MSBs differ) from empty (all equal).
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign level     = wr_ptr - rd_ptr;
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/match_gap_logger.sv
// match_gap_logger: counts detector match pulses and queues inter-match gaps for a reader.
`default_nettype none

module match_gap_logger
    import match_log_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       match_in,
    input  logic                       clear_ovf,
    output logic                       gap_valid,
    input  logic                       gap_ready,
    output logic [GAP_W-1:0]           gap_data,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow
);

    mlog_state_t      state;
    logic [GAP_W-1:0] timer;
    logic [CNT_W-1:0] count;
    logic             match_prev;
    logic             evt;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign evt         = enable & match_in & ~match_prev;
    assign push        = evt & (state == ARMED);
    assign pop         = gap_valid & gap_ready;
    assign gap_valid   = ~empty;
    assign match_count = count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            count      <= '0;
            match_prev <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            match_prev <= match_in;

            // Setting takes priority over a coincident clear.
            if (push & full & ~pop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;

            if (!enable) begin
                state <= IDLE;
            end else if (evt) begin
                state <= ARMED;
                timer <= GAP_W'(1);
                if (count != '1) count <= count + 1'b1;
            end else if (state == ARMED && timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

    sync_fifo_vr #(
        .WIDTH (GAP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (timer),
        .pop       (pop),
        .head_data (gap_data),
        .level     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_match_gap_logger.sv
// tb_match_gap_logger: directed plus random stimulus against a queue-based reference model.
`default_nettype none

module tb_match_gap_logger;

    localparam int GAP_W   = 4;
    localparam int CNT_W   = 5;
    localparam int DEPTH   = 4;
    localparam int GAP_MAX = (1 << GAP_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic                       enable = 1'b0;
    logic                       match_in = 1'b0;
    logic                       clear_ovf = 1'b0;
    logic                       gap_ready = 1'b0;
    logic                       gap_valid;
    logic [GAP_W-1:0]           gap_data;
    logic [CNT_W-1:0]           match_count;
    logic [$clog2(DEPTH+1)-1:0] fifo_level;
    logic                       overflow;

    int tests = 0;
    int fails = 0;

    // Reference model: arrival times of events and a queue of gaps.
    int q[$];
    int cyc = 0;
    int last_t = 0;
    bit armed = 0;
    bit m_prev = 0;
    int m_cnt = 0;
    bit m_ovf = 0;

    always #5 clk = ~clk;

    match_gap_logger #(
        .GAP_W (GAP_W),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .match_in    (match_in),
        .clear_ovf   (clear_ovf),
        .gap_valid   (gap_valid),
        .gap_ready   (gap_ready),
        .gap_data    (gap_data),
        .match_count (match_count),
        .fifo_level  (fifo_level),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock with the current inputs, update the model, then compare.
    task automatic step();
        bit evt;
        bit pop;
        bit full_before;
        int gap;
        @(posedge clk);
        if (!reset) begin
            q.delete();
            armed  = 0;
            m_prev = 0;
            m_cnt  = 0;
            m_ovf  = 0;
        end else begin
            evt         = enable && match_in && !m_prev;
            pop         = (q.size() > 0) && gap_ready;
            full_before = (q.size() == DEPTH);
            gap         = cyc - last_t;
            if (gap > GAP_MAX) gap = GAP_MAX;
            if (pop) void'(q.pop_front());
            if (evt && armed) begin
                if (full_before && !pop) m_ovf = 1;
                else q.push_back(gap);
            end else if (clear_ovf) begin
                m_ovf = 0;
            end
            if (evt && armed && full_before && !pop) m_ovf = 1;
            else if (clear_ovf && !(evt && armed && full_before && !pop)) m_ovf = 0;
            if (evt) begin
                last_t = cyc;
                armed  = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (!enable) armed = 0;
            m_prev = match_in;
        end
        cyc++;
        #1;
        chk("gap_valid", int'(gap_valid), (q.size() > 0) ? 1 : 0);
        chk("gap_data", int'(gap_data), (q.size() > 0) ? q[0] : 0);
        chk("match_count", int'(match_count), m_cnt);
        chk("fifo_level", int'(fifo_level), q.size());
        chk("overflow", int'(overflow), int'(m_ovf));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse();
        match_in = 1'b1;
        step();
        match_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        match_in = 1'b0;
        clear_ovf = 1'b0;
        gap_ready = 1'b0;
        run(2);
        reset = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_count", int'(match_count), 0);

        // Test 1: pulses 3 and 7 cycles apart, reader stalled then draining
        run(9); pulse(); run(2); pulse(); run(6); pulse(); run(2);
        chk("t1_count", int'(match_count), 3);
        chk("t1_level", int'(fifo_level), 2);
        chk("t1_head", int'(gap_data), 3);
        gap_ready = 1'b1; run(3); gap_ready = 1'b0;
        chk("t1_drained", int'(gap_valid), 0);

        // Test 2: held-high match yields one event
        do_reset();
        run(4); match_in = 1'b1; run(5); match_in = 1'b0; run(5); pulse(); run(2);
        chk("t2_count", int'(match_count), 2);
        chk("t2_head", int'(gap_data), 10);

        // Test 3: overflow with stalled reader, then drain and clear
        do_reset();
        for (int i = 0; i < 6; i++) begin pulse(); run(3); end
        chk("t3_level", int'(fifo_level), 4);
        chk("t3_ovf", int'(overflow), 1);
        gap_ready = 1'b1; run(4); gap_ready = 1'b0;
        clear_ovf = 1'b1; step(); clear_ovf = 1'b0;
        chk("t3_clr", int'(overflow), 0);

        // Test 4: full FIFO, event coincident with a pop
        do_reset();
        for (int i = 0; i < 5; i++) begin pulse(); run(3); end
        run(2);
        gap_ready = 1'b1; pulse(); gap_ready = 1'b0;
        chk("t4_level", int'(fifo_level), 4);
        chk("t4_ovf", int'(overflow), 0);

        // Test 5: gap saturation
        do_reset();
        pulse(); run(19); pulse(); step();
        chk("t5_sat", int'(gap_data), GAP_MAX);

        // Test 6: enable drop re-arms without push, then mid-stream reset
        do_reset();
        pulse(); run(4); enable = 1'b0; run(3); enable = 1'b1; run(2);
        pulse(); run(3);
        chk("t6_nopush", int'(fifo_level), 0);
        pulse(); run(2);
        chk("t6_push", int'(gap_data), 4);
        reset = 1'b0; step(); reset = 1'b1;
        chk("t6_rst_count", int'(match_count), 0);

        // Random stimulus
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            match_in  = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 15) != 0);
            gap_ready = ($urandom_range(0, 3) == 0);
            clear_ovf = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
